// File: rtl/dh_partner_param.sv
// Diffie-Hellman partner: holds prime/base, draws secrets from a Galois LFSR and
// computes pub/shared keys with a constant-time bit-serial modular exponentiator.
module dh_partner_param #(
    parameter int          WIDTH       = 128,
    parameter int          SECRET_BITS = 32,
    parameter logic [63:0] LFSR_POLY   = 64'h0000_0000_8020_0003
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [1:0]             cmd_op,
    input  logic [WIDTH-1:0]       prime_in,
    input  logic [WIDTH-1:0]       base_in,
    input  logic [WIDTH-1:0]       peer_key_in,
    input  logic [SECRET_BITS-1:0] seed_in,
    output logic [WIDTH-1:0]       pub_key,
    output logic                   pub_valid,
    output logic [WIDTH-1:0]       shared_key,
    output logic                   shared_valid,
    output logic                   busy,
    output logic                   done,
    output logic                   err
);

    localparam int CW = $clog2(WIDTH);
    localparam int BW = $clog2(SECRET_BITS);

    localparam logic [1:0] OP_LOAD   = 2'b00;
    localparam logic [1:0] OP_GEN    = 2'b01;
    localparam logic [1:0] OP_DERIVE = 2'b10;
    localparam logic [1:0] OP_CLEAR  = 2'b11;

    localparam logic [CW-1:0]          LAST_A   = CW'(WIDTH - 1);
    localparam logic [CW-1:0]          LAST_B   = CW'(WIDTH - 2);
    localparam logic [CW-1:0]          CNT_ONE  = CW'(32'd1);
    localparam logic [BW-1:0]          LAST_BIT = BW'(SECRET_BITS - 1);
    localparam logic [BW-1:0]          BIT_ONE  = BW'(32'd1);
    localparam logic [WIDTH-1:0]       W_ONE    = WIDTH'(32'd1);
    localparam logic [WIDTH-1:0]       W_TWO    = WIDTH'(32'd2);
    localparam logic [WIDTH-1:0]       W_THREE  = WIDTH'(32'd3);
    localparam logic [SECRET_BITS-1:0] S_ONE    = SECRET_BITS'(32'd1);
    localparam logic [SECRET_BITS-1:0] POLY     = LFSR_POLY[SECRET_BITS-1:0];

    typedef enum logic [2:0] {
        S_IDLE, S_CHECK, S_MUL_LOAD, S_MUL_STEP, S_NEXT_BIT, S_FINISH
    } state_t;

    state_t state_r, state_nx;

    logic [1:0]             op_r;
    logic [WIDTH-1:0]       prime_st_r, base_st_r, peer_st_r;
    logic [SECRET_BITS-1:0] seed_st_r;
    logic [WIDTH-1:0]       prime_r, base_r;
    logic                   params_loaded_r, secret_valid_r, long_r;
    logic [SECRET_BITS-1:0] lfsr_r, secret_r, exp_r;
    logic [WIDTH-1:0]       res_r, bcur_r, acc_r, mcand_r, mplier_r;
    logic [CW-1:0]          cnt_r;
    logic [BW-1:0]          bit_cnt_r;
    logic                   phase_r;
    logic                   chk_err_s;
    logic [WIDTH-1:0]       step_s;

    // One interleaved step: double then conditionally add, each followed by a single
    // conditional subtract; operands below p keep the WIDTH+1 bit value under 2p.
    function automatic logic [WIDTH-1:0] mod_step(input logic [WIDTH-1:0] acc,
                                                  input logic [WIDTH-1:0] a,
                                                  input logic             mbit,
                                                  input logic [WIDTH-1:0] p);
        logic [WIDTH:0] t;
        t = {acc, 1'b0};
        if (t >= {1'b0, p}) t = t - {1'b0, p};
        else                t = t;
        if (mbit) begin
            t = t + {1'b0, a};
            if (t >= {1'b0, p}) t = t - {1'b0, p};
            else                t = t;
        end else begin
            t = t;
        end
        return t[WIDTH-1:0];
    endfunction

    function automatic logic [SECRET_BITS-1:0] lfsr_next(input logic [SECRET_BITS-1:0] s);
        if (s[0]) return (s >> 1) ^ POLY;
        else      return s >> 1;
    endfunction

    assign cmd_ready = (state_r == S_IDLE);

    // Multiplier datapath step and command legality check.
    always_comb begin
        step_s    = mod_step(acc_r, mcand_r, mplier_r[WIDTH-1], prime_r);
        chk_err_s = 1'b0;
        case (op_r)
            OP_LOAD:   chk_err_s = (prime_st_r < W_THREE) || (base_st_r < W_TWO) ||
                                   (base_st_r >= prime_st_r);
            OP_GEN:    chk_err_s = !params_loaded_r;
            OP_DERIVE: chk_err_s = !params_loaded_r || !secret_valid_r ||
                                   (peer_st_r < W_TWO) || (peer_st_r >= prime_r);
            default:   chk_err_s = 1'b0;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_r <= S_IDLE;
        else     state_r <= state_nx;
    end

    // Next-state logic; the squaring multiply's last step is folded into NEXT_BIT.
    always_comb begin
        state_nx = state_r;
        case (state_r)
            S_IDLE: begin
                if (cmd_valid) state_nx = S_CHECK;
                else           state_nx = S_IDLE;
            end
            S_CHECK: begin
                if (chk_err_s || op_r == OP_LOAD || op_r == OP_CLEAR) state_nx = S_FINISH;
                else                                                  state_nx = S_MUL_LOAD;
            end
            S_MUL_LOAD: state_nx = S_MUL_STEP;
            S_MUL_STEP: begin
                if (!phase_r) begin
                    if (cnt_r == LAST_A) state_nx = S_MUL_LOAD;
                    else                 state_nx = S_MUL_STEP;
                end else begin
                    if (cnt_r == LAST_B) state_nx = S_NEXT_BIT;
                    else                 state_nx = S_MUL_STEP;
                end
            end
            S_NEXT_BIT: begin
                if (bit_cnt_r == LAST_BIT) state_nx = S_FINISH;
                else                       state_nx = S_MUL_LOAD;
            end
            S_FINISH: state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    // Command capture, parameter/secret registers, exponentiator and result outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_r            <= 2'b00;
            prime_st_r      <= '0;
            base_st_r       <= '0;
            peer_st_r       <= '0;
            seed_st_r       <= '0;
            prime_r         <= '0;
            base_r          <= '0;
            params_loaded_r <= 1'b0;
            secret_valid_r  <= 1'b0;
            long_r          <= 1'b0;
            lfsr_r          <= S_ONE;
            secret_r        <= '0;
            exp_r           <= '0;
            res_r           <= '0;
            bcur_r          <= '0;
            acc_r           <= '0;
            mcand_r         <= '0;
            mplier_r        <= '0;
            cnt_r           <= '0;
            bit_cnt_r       <= '0;
            phase_r         <= 1'b0;
            pub_key         <= '0;
            pub_valid       <= 1'b0;
            shared_key      <= '0;
            shared_valid    <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
            err             <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (cmd_valid) begin
                        op_r       <= cmd_op;
                        prime_st_r <= prime_in;
                        base_st_r  <= base_in;
                        peer_st_r  <= peer_key_in;
                        seed_st_r  <= seed_in;
                        busy       <= 1'b1;
                    end
                end
                S_CHECK: begin
                    long_r    <= 1'b0;
                    phase_r   <= 1'b0;
                    bit_cnt_r <= '0;
                    res_r     <= W_ONE;
                    if (chk_err_s) begin
                        err  <= 1'b1;
                        done <= 1'b1;
                        busy <= 1'b0;
                    end else begin
                        case (op_r)
                            OP_LOAD: begin
                                prime_r         <= prime_st_r;
                                base_r          <= base_st_r;
                                lfsr_r          <= (seed_st_r == '0) ? S_ONE : seed_st_r;
                                params_loaded_r <= 1'b1;
                                secret_r        <= '0;
                                secret_valid_r  <= 1'b0;
                                pub_valid       <= 1'b0;
                                shared_valid    <= 1'b0;
                                done            <= 1'b1;
                                busy            <= 1'b0;
                            end
                            OP_GEN: begin
                                secret_r       <= lfsr_r;
                                exp_r          <= lfsr_r;
                                lfsr_r         <= lfsr_next(lfsr_r);
                                secret_valid_r <= 1'b1;
                                bcur_r         <= base_r;
                                long_r         <= 1'b1;
                            end
                            OP_DERIVE: begin
                                exp_r  <= secret_r;
                                bcur_r <= peer_st_r;
                                long_r <= 1'b1;
                            end
                            default: begin
                                secret_r       <= '0;
                                secret_valid_r <= 1'b0;
                                pub_key        <= '0;
                                shared_key     <= '0;
                                pub_valid      <= 1'b0;
                                shared_valid   <= 1'b0;
                                done           <= 1'b1;
                                busy           <= 1'b0;
                            end
                        endcase
                    end
                end
                S_MUL_LOAD: begin
                    acc_r    <= '0;
                    mcand_r  <= phase_r ? bcur_r : res_r;
                    mplier_r <= bcur_r;
                    cnt_r    <= '0;
                end
                S_MUL_STEP: begin
                    acc_r    <= step_s;
                    mplier_r <= mplier_r << 1;
                    cnt_r    <= cnt_r + CNT_ONE;
                    // Product is always formed; it only lands in res_r for a set bit.
                    if (!phase_r && cnt_r == LAST_A) begin
                        phase_r <= 1'b1;
                        res_r   <= exp_r[0] ? step_s : res_r;
                    end
                end
                S_NEXT_BIT: begin
                    bcur_r    <= step_s;
                    exp_r     <= exp_r >> 1;
                    bit_cnt_r <= bit_cnt_r + BIT_ONE;
                    phase_r   <= 1'b0;
                end
                S_FINISH: begin
                    long_r <= 1'b0;
                    if (long_r) begin
                        done <= 1'b1;
                        busy <= 1'b0;
                        if (op_r == OP_GEN) begin
                            pub_key      <= res_r;
                            pub_valid    <= 1'b1;
                            shared_valid <= 1'b0;
                        end else begin
                            shared_key   <= res_r;
                            shared_valid <= 1'b1;
                        end
                    end
                end
                default: busy <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_dh_partner_param.sv
// Randomised scoreboard bench for dh_partner_param (WIDTH=16, SECRET_BITS=8):
// a command-level reference model predicts every done pulse and its latency.
module tb_dh_partner_param;

    localparam int W  = 16;
    localparam int SB = 8;
    localparam int L  = 2 * SB * (W + 1) + 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [W-1:0]  prime_in, base_in, peer_key_in;
    logic [SB-1:0] seed_in;
    logic [W-1:0]  pub_key, shared_key;
    logic          pub_valid, shared_valid, busy, done, err;

    dh_partner_param #(.WIDTH(W), .SECRET_BITS(SB)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .prime_in(prime_in), .base_in(base_in),
        .peer_key_in(peer_key_in), .seed_in(seed_in), .pub_key(pub_key),
        .pub_valid(pub_valid), .shared_key(shared_key), .shared_valid(shared_valid),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        int           acc;
        int           lat;
        logic         e;
        logic [W-1:0] pk;
        logic         pv;
        logic [W-1:0] sk;
        logic         sv;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;

    // reference model state
    logic         m_loaded, m_sec_ok, m_pv, m_sv;
    int           m_p, m_g;
    logic [7:0]   m_lfsr, m_secret;
    logic [W-1:0] m_pub, m_sh;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    function automatic int powmod(input int b, input int e, input int p);
        longint r;
        r = 1;
        for (int i = 0; i < e; i++) r = (r * b) % p;
        return int'(r);
    endfunction

    function automatic logic [7:0] lfsr_step(input logic [7:0] s);
        logic [7:0] n;
        n = s >> 1;
        if (s[0]) n = n ^ 8'h03;
        return n;
    endfunction

    task automatic model_reset();
        m_loaded = 1'b0; m_sec_ok = 1'b0; m_pv = 1'b0; m_sv = 1'b0;
        m_p = 0; m_g = 0; m_lfsr = 8'd1; m_secret = 8'd0;
        m_pub = '0; m_sh = '0;
    endtask

    task automatic model_cmd(input int op, input int a, input int b, input int peer,
                             input int seed, input int acc);
        exp_t e;
        logic bad;
        bad   = 1'b0;
        e.acc = acc;
        e.lat = 1;
        case (op)
            0: begin
                bad = (a < 3) || (b < 2) || (b >= a);
                if (!bad) begin
                    m_p = a; m_g = b; m_loaded = 1'b1;
                    m_lfsr = (seed == 0) ? 8'd1 : 8'(seed);
                    m_secret = 8'd0; m_sec_ok = 1'b0; m_pv = 1'b0; m_sv = 1'b0;
                end
            end
            1: begin
                bad = !m_loaded;
                if (!bad) begin
                    m_secret = m_lfsr;
                    m_lfsr   = lfsr_step(m_lfsr);
                    m_sec_ok = 1'b1;
                    m_pub    = W'(powmod(m_g, int'(m_secret), m_p));
                    m_pv     = 1'b1;
                    m_sv     = 1'b0;
                    e.lat    = L;
                end
            end
            2: begin
                bad = !m_loaded || !m_sec_ok || (peer < 2) || (peer >= m_p);
                if (!bad) begin
                    m_sh  = W'(powmod(peer, int'(m_secret), m_p));
                    m_sv  = 1'b1;
                    e.lat = L;
                end
            end
            default: begin
                m_secret = 8'd0; m_sec_ok = 1'b0;
                m_pub = '0; m_sh = '0; m_pv = 1'b0; m_sv = 1'b0;
            end
        endcase
        e.e = bad; e.pk = m_pub; e.pv = m_pv; e.sk = m_sh; e.sv = m_sv;
        sb.push_back(e);
    endtask

    task automatic issue(input int op, input int a, input int b, input int peer, input int seed);
        int t;
        t = 0;
        while (!cmd_ready && t < 2000) begin
            @(negedge clk);
            t++;
        end
        cmd_op      = 2'(op);
        prime_in    = W'(a);
        base_in     = W'(b);
        peer_key_in = W'(peer);
        seed_in     = SB'(seed);
        cmd_valid   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        model_cmd(op, a, b, peer, seed, cyc);
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while ((sb.size() != 0 || !cmd_ready) && t < 2000) begin
            @(negedge clk);
            t++;
        end
        chk("idle_pending", 64'(sb.size()), 64'd0);
        if (sb.size() != 0) sb.delete();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_pub_key"}, 64'(pub_key), 64'd0);
        chk({tag, "_shared_key"}, 64'(shared_key), 64'd0);
        chk({tag, "_pub_valid"}, 64'(pub_valid), 64'd0);
        chk({tag, "_shared_valid"}, 64'(shared_valid), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_err"}, 64'(err), 64'd0);
        chk({tag, "_cmd_ready"}, 64'(cmd_ready), 64'd1);
    endtask

    // Monitor: every done pulse is matched against the oldest prediction.
    always @(negedge clk) begin
        if (!rst) begin
            if (err) chk("err_with_done", 64'(done), 64'd1);
            if (done) begin
                if (sb.size() == 0) begin
                    chk("spurious_done", 64'(done), 64'd0);
                end else begin
                    mon_e = sb.pop_front();
                    chk("latency", 64'(cyc - mon_e.acc), 64'(mon_e.lat));
                    chk("err", 64'(err), 64'(mon_e.e));
                    chk("pub_key", 64'(pub_key), 64'(mon_e.pk));
                    chk("pub_valid", 64'(pub_valid), 64'(mon_e.pv));
                    chk("shared_key", 64'(shared_key), 64'(mon_e.sk));
                    chk("shared_valid", 64'(shared_valid), 64'(mon_e.sv));
                end
            end
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        int op, a, b, peer, seed, r, t;
        logic seen;
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00;
        prime_in = '0; base_in = '0; peer_key_in = '0; seed_in = '0;
        model_reset();
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        // directed vectors from known small-prime results
        issue(1, 0, 0, 0, 0); wait_idle();
        issue(0, 23, 5, 0, 6); wait_idle();
        issue(1, 0, 0, 0, 0); wait_idle();
        chk("gen_seed6_pub", 64'(pub_key), 64'd8);
        chk("gen_seed6_pv", 64'(pub_valid), 64'd1);
        issue(2, 0, 0, 0, 0); wait_idle();
        chk("derive_peer0_sv", 64'(shared_valid), 64'd0);
        issue(0, 23, 23, 0, 0); wait_idle();
        issue(2, 0, 0, 19, 0); wait_idle();
        chk("derive_peer19", 64'(shared_key), 64'd2);
        issue(0, 23, 5, 0, 15); wait_idle();
        issue(1, 0, 0, 0, 0); wait_idle();
        chk("gen_seed15_pub", 64'(pub_key), 64'd19);
        issue(2, 0, 0, 8, 0); wait_idle();
        chk("derive_peer8", 64'(shared_key), 64'd2);

        issue(0, 23, 5, 0, 6); wait_idle();
        issue(1, 0, 0, 0, 0); wait_idle();
        issue(2, 0, 0, 19, 0); wait_idle();
        issue(3, 0, 0, 0, 0); wait_idle();
        chk("clear_pv", 64'(pub_valid), 64'd0);
        chk("clear_sv", 64'(shared_valid), 64'd0);
        chk("clear_pub", 64'(pub_key), 64'd0);
        chk("clear_sh", 64'(shared_key), 64'd0);
        issue(1, 0, 0, 0, 0); wait_idle();
        chk("gen_after_clear_pub", 64'(pub_key), 64'd10);

        // cmd_valid held high through a whole GEN_KEY
        cmd_op = 2'b01; cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        model_cmd(1, 0, 0, 0, 0, cyc);
        seen = 1'b0;
        t = 0;
        while (!seen && t < L + 20) begin
            if (done) begin
                seen = 1'b1;
            end else begin
                chk("held_cmd_ready", 64'(cmd_ready), 64'd0);
                chk("held_busy", 64'(busy), 64'd1);
                @(negedge clk);
                t++;
            end
        end
        cmd_valid = 1'b0;
        chk("held_done_seen", 64'(seen), 64'd1);
        repeat (5) @(negedge clk);
        wait_idle();

        // reset in the middle of a computation
        issue(1, 0, 0, 0, 0);
        repeat (99) @(negedge clk);
        rst = 1'b1;
        #1;
        chk_reset_outputs("midrun_reset");
        sb.delete();
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        issue(1, 0, 0, 0, 0); wait_idle();

        // randomised command stream
        issue(0, 65521, 3, 0, 77); wait_idle();
        for (int i = 0; i < 30; i++) begin
            r = $urandom_range(0, 9);
            if (r < 2)      op = 0;
            else if (r < 6) op = 1;
            else if (r < 9) op = 2;
            else            op = 3;
            if ($urandom_range(0, 5) == 0) a = $urandom_range(0, 4);
            else                           a = $urandom_range(3, 65535);
            if ($urandom_range(0, 4) == 0 || a < 3) b = $urandom_range(0, 65535);
            else                                    b = $urandom_range(2, a - 1);
            if (m_p >= 3 && $urandom_range(0, 3) != 0) peer = $urandom_range(2, m_p - 1);
            else                                       peer = $urandom_range(0, 65535);
            seed = $urandom_range(0, 255);
            if (seed > 200) seed = 0;
            issue(op, a, b, peer, seed);
            wait_idle();
        end

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/dh_partner_param.md
DH_PARTNER_PARAM -- requirements
Module: dh_partner_param

Interface
REQ-001 SHALL have parameter WIDTH, default 128, meaning the bit width of prime, base and keys (legal range 8..256).
REQ-002 SHALL have parameter SECRET_BITS, default 32, meaning the secret exponent width (legal range 4..64, at most WIDTH).
REQ-003 SHALL have parameter LFSR_POLY, default 32'h8020_0003, meaning the Galois LFSR tap mask (low SECRET_BITS bits used).
REQ-004 SHALL have port clk, input, 1 bit: the clock.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port cmd_valid, input, 1 bit: command request.
REQ-007 SHALL have port cmd_ready, output, 1 bit: high only in IDLE.
REQ-008 SHALL have port cmd_op, input, 2 bits: 00 LOAD, 01 GEN_KEY, 10 DERIVE, 11 CLEAR.
REQ-009 SHALL have ports prime_in, base_in and peer_key_in, inputs, WIDTH bits each: operands.
REQ-010 SHALL have port seed_in, input, SECRET_BITS: LFSR seed.
REQ-011 SHALL have port pub_key, output, WIDTH bits, with pub_valid, output, 1 bit.
REQ-012 SHALL have port shared_key, output, WIDTH bits, with shared_valid, output, 1 bit.
REQ-013 SHALL have port busy, output, 1 bit; done, output, 1 bit (one-cycle pulse); err, output, 1 bit (one-cycle pulse, coincident with done).

Function
REQ-014 SHALL accept a command on the rising clk edge where cmd_valid and cmd_ready are both high; operands are sampled only at that edge.
REQ-015 LOAD SHALL register prime and base, set LFSR to seed_in (0 replaced by 1), clear secret, pub_valid and shared_valid, and pulse done 1 cycle later.
REQ-016 LOAD SHALL pulse err with no register change if prime_in < 3 or base_in < 2 or base_in >= prime_in.
REQ-017 GEN_KEY SHALL capture secret = current LFSR state, then step the LFSR once, and compute pub_key = base^secret mod prime.
REQ-018 DERIVE SHALL compute shared_key = peer_key_in^secret mod prime; it SHALL pulse err without computing if no params are loaded, no secret exists, or peer_key_in < 2 or peer_key_in >= prime.
REQ-019 GEN_KEY with no params loaded SHALL pulse err 1 cycle after accept.
REQ-020 CLEAR SHALL zero secret, pub_key and shared_key, drop both valid flags, keep prime, base and LFSR, and pulse done 1 cycle later.
REQ-021 The FSM SHALL have states IDLE, CHECK, MUL_LOAD, MUL_STEP, NEXT_BIT, FINISH: IDLE→CHECK on accept; CHECK→FINISH on error, LOAD or CLEAR, else →MUL_LOAD; MUL_LOAD→MUL_STEP; MUL_STEP→MUL_LOAD after WIDTH steps of the first multiply, →NEXT_BIT after the second; NEXT_BIT→MUL_LOAD or FINISH after SECRET_BITS bits; FINISH→IDLE.
REQ-022 Exponentiation SHALL be right-to-left square-and-multiply, constant time: for every exponent bit it SHALL run both result·base and base·base, discarding the product when the bit is 0.
REQ-023 Modular multiply SHALL be MSB-first interleaved: acc=(2·acc) mod p, then acc=(acc+a) mod p if the multiplier bit is set, one bit per cycle; intermediates are WIDTH+1 bits and never exceed 2p-1 before reduction.
REQ-024 GEN_KEY and DERIVE latency SHALL be exactly L = 2·SECRET_BITS·(WIDTH+1)+2 cycles from the accept edge to the done pulse.
REQ-025 The result register and its valid flag SHALL update on the same edge as done; the other result and valid flag are untouched.
REQ-026 busy SHALL be high from the accept edge until the done edge inclusive; cmd_valid while busy is ignored and not queued.
REQ-027 DERIVE SHALL use the secret from the most recent GEN_KEY; a new GEN_KEY SHALL drop shared_valid.

Reset
REQ-028 rst SHALL force IDLE; outputs pub_key=0, shared_key=0, pub_valid=0, shared_valid=0, busy=0, done=0, err=0, cmd_ready=1; params_loaded=0, secret=0, LFSR=1.
REQ-029 rst asserted mid-computation SHALL abort immediately with no done or err pulse and no partial result visible.

Verification (WIDTH=16, SECRET_BITS=8, L=274)
REQ-030 LOAD p=23, g=5, seed=6 then GEN_KEY -> done exactly 274 cycles after accept, pub_key=8, pub_valid=1.
REQ-031 Second instance, LOAD p=23, g=5, seed=15, GEN_KEY -> pub_key=19; DERIVE with peer 8 -> shared_key=2; first instance DERIVE with peer 19 -> shared_key=2.
REQ-032 LOAD base_in=23 with p=23 -> err and done pulse 1 cycle later, params unchanged; DERIVE peer_key_in=0 -> err, shared_valid stays 0.
REQ-033 cmd_valid held high while busy -> cmd_ready=0, no extra done pulse, result unchanged.
REQ-034 rst pulsed at cycle 100 of GEN_KEY -> all outputs 0 next cycle, no done; GEN_KEY after reset -> err (no params).
REQ-035 CLEAR after DERIVE -> both valid flags 0, keys 0; GEN_KEY then gives secret = next LFSR state, not seed.
